up_down_count_checker: RTL and testbench
========================================

Name: up_down_count_checker

Overview:
Receive-side monitor for the up/down counter. It samples the counter's `count` and `mode` lines every `clk` cycle and predicts the next value from the direction. It locks onto the sequence, then flags every illegal step: skip, stall, wrong direction or glitch. It sits beside the counter in the counter subsystem and in its benches as a self-checking consumer.

Parameters:
- WIDTH, 4, width of the observed count bus.
- LOCK_N, 4, consecutive legal steps required to declare lock (1..15).
- ERRW, 8, width of the saturating error counter.

Ports:
- clk  input  1  sampling clock; same clock that drives the counter.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  counter direction: 0 = up, 1 = down.
- count  input  WIDTH  observed counter value.
- locked  output  1  high while in TRACK.
- err_pulse  output  1  one-cycle strobe per illegal step while locked.
- err_count  output  ERRW  number of illegal steps seen while locked; saturates.
- expected  output  WIDTH  predicted value for the next sample; valid when `locked`=1.

Behaviour:
- Reset (async, rst=1):
  - state = IDLE.
  - `locked`, `err_pulse`, `err_count`, `expected`, `match_cnt` = 0.
  - All sample registers = 0.
  - Reset asserted mid-operation clears everything immediately, including lock and `err_count`.
- Sample stage: on each posedge, `count_q<=count`, `prev_q<=count_q`, `mode_q<=mode`, `mode_qq<=mode_q`.
- Step legality, evaluated on (`prev_q`, `count_q`) with WIDTH-bit modular arithmetic:
  - up_ok = (`count_q` == `prev_q`+1).
  - dn_ok = (`count_q` == `prev_q`-1).
  - Wrap is legal: 4'hF to 4'h0 when counting up, 4'h0 to 4'hF when counting down.
  - If `mode_q` == `mode_qq`: legal = (`mode_qq`==0 ? up_ok : dn_ok).
  - If `mode_q` != `mode_qq` (direction-change grace cycle): legal = up_ok | dn_ok.
  - No change (stall) is illegal.
- State machine:
  - IDLE: wait two edges after reset release so that `prev_q` and `count_q` both hold real samples, then go to SYNC.
  - SYNC: each legal step increments `match_cnt`. An illegal step clears `match_cnt` and does not pulse `err_pulse`. When `match_cnt` reaches LOCK_N, go to TRACK; `locked` goes to 1 on the same edge.
  - TRACK: each illegal step does the following on the same edge:
    - `err_pulse` = 1 for exactly one cycle;
    - `err_count` increments, saturating at 2^ERRW-1;
    - state returns to SYNC with `match_cnt` = 0 and `locked` = 0.
- `expected` is updated every edge to `count_q`+1 or `count_q`-1, selecting on `mode_q`.
- Latency: a bad value on `count` sampled at edge N raises `err_pulse` during the cycle following edge N+1. All outputs are registered.
- `count` is not synchronised. It must be settled at the sampling posedge; a multi-bit ripple transient sampled mid-flight is treated as an illegal step.

Decomposition:
- Package `counter_check_pkg`:
  - state enum `chk_state_e` {IDLE, SYNC, TRACK};
  - direction constants `DIR_UP`=1'b0, `DIR_DN`=1'b1;
  - default values for WIDTH, LOCK_N and ERRW.
- Sub-module `count_step_judge`: combinational. Takes `prev_q`, `count_q`, `mode_q`, `mode_qq` and produces `legal` plus next `expected`.
- The top module holds the sample registers, FSM and counters.

Test Plan:
- Ideal up count from 0 with mode=0, rst released at 30 ns, 10 ns clock → `locked`=1 after 2+LOCK_N legal steps; `err_count`=0; `expected` tracks `count`+1.
- Wrap-around: run up through 4'hF to 4'h0, then mode=1 down through 4'h0 to 4'hF → no `err_pulse`, `locked` stays 1 throughout.
- Mode flip at count 4'h7 (up to down) → grace cycle accepts 4'h8 or 4'h6; no error; `locked` stays 1.
- While locked, force a skip 4'h3 to 4'h5 → one `err_pulse` cycle, `err_count`=1, `locked`=0; relock after LOCK_N good steps.
- Stall (count held at 4'hA for 2 cycles) while locked → exactly 1 `err_pulse` (the FSM is then in SYNC); `err_count`=1.
- Assert rst for 1 ns mid-TRACK with `err_count`=3 → all outputs 0 immediately, state IDLE; relock sequence repeats.

Source files
------------

// File: rtl/up_down_count_checker_pkg.sv
// Shared types and defaults for the up/down counter receive-side checker.
package counter_check_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    TRACK
  } chk_state_e;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  localparam int unsigned DEF_WIDTH  = 4;
  localparam int unsigned DEF_LOCK_N = 4;
  localparam int unsigned DEF_ERRW   = 8;

endpackage

// File: rtl/up_down_count_checker_judge.sv
// Combinational step judge: decides whether prev_q -> count_q is a legal
// counter step for the sampled direction, and forms the next prediction.
module count_step_judge
  import counter_check_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] prev_q,
  input  logic [WIDTH-1:0] count_q,
  input  logic             mode_q,
  input  logic             mode_qq,
  output logic             legal,
  output logic [WIDTH-1:0] expected_next
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic up_ok;
  logic dn_ok;

  always_comb begin
    up_ok = (count_q == prev_q + ONE);
    dn_ok = (count_q == prev_q - ONE);
    // A direction change gives one grace step in either direction.
    if (mode_q == mode_qq) begin
      legal = (mode_qq == DIR_UP) ? up_ok : dn_ok;
    end else begin
      legal = up_ok | dn_ok;
    end
    expected_next = (mode_q == DIR_DN) ? (count_q - ONE) : (count_q + ONE);
  end

endmodule

// File: rtl/up_down_count_checker.sv
// Receive-side monitor for the up/down counter: samples count/mode, locks onto
// the sequence and reports every illegal step once locked.
module up_down_count_checker
  import counter_check_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned LOCK_N = DEF_LOCK_N,
  parameter int unsigned ERRW   = DEF_ERRW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [WIDTH-1:0] count,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERRW-1:0]  err_count,
  output logic [WIDTH-1:0] expected
);

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_N);

  chk_state_e       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             mode_q, mode_d;
  logic             mode_qq, mode_qq_d;
  logic             idle_q, idle_d;
  logic [3:0]       match_q, match_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERRW-1:0]  err_count_q, err_count_d;
  logic [WIDTH-1:0] expected_q, expected_d;

  logic             legal;
  logic [WIDTH-1:0] expected_next;

  count_step_judge #(
    .WIDTH(WIDTH)
  ) u_judge (
    .prev_q       (prev_q),
    .count_q      (count_q),
    .mode_q       (mode_q),
    .mode_qq      (mode_qq),
    .legal        (legal),
    .expected_next(expected_next)
  );

  always_comb begin
    count_d     = count;
    prev_d      = count_q;
    mode_d      = mode;
    mode_qq_d   = mode_q;
    state_d     = state_q;
    idle_d      = idle_q;
    match_d     = match_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    expected_d  = expected_next;

    case (state_q)
      IDLE: begin
        // Two edges are needed before prev_q and count_q both hold real samples.
        if (idle_q) begin
          state_d = SYNC;
        end else begin
          idle_d = 1'b1;
        end
      end
      SYNC: begin
        if (legal) begin
          match_d = match_q + 4'd1;
          if (match_d == LOCK_TGT) begin
            state_d  = TRACK;
            locked_d = 1'b1;
          end
        end else begin
          match_d = '0;
        end
      end
      TRACK: begin
        if (!legal) begin
          err_pulse_d = 1'b1;
          if (!(&err_count_q)) begin
            err_count_d = err_count_q + ERRW'(1);
          end
          state_d  = SYNC;
          match_d  = '0;
          locked_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      prev_q      <= '0;
      mode_q      <= 1'b0;
      mode_qq     <= 1'b0;
      idle_q      <= 1'b0;
      match_q     <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      expected_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      prev_q      <= prev_d;
      mode_q      <= mode_d;
      mode_qq     <= mode_qq_d;
      idle_q      <= idle_d;
      match_q     <= match_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      expected_q  <= expected_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign expected  = expected_q;

endmodule

// File: tb/tb_up_down_count_checker.sv
// Scoreboard bench for up_down_count_checker: directed count/mode sequences,
// per-cycle expectations queued at drive time, plus hand-computed spot checks.
module tb_up_down_count_checker;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned LOCK_N = 4;
  localparam int unsigned ERRW   = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             mode = 1'b0;
  logic [WIDTH-1:0] count = '0;
  logic             locked;
  logic             err_pulse;
  logic [ERRW-1:0]  err_count;
  logic [WIDTH-1:0] expected;

  up_down_count_checker #(
    .WIDTH (WIDTH),
    .LOCK_N(LOCK_N),
    .ERRW  (ERRW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .count    (count),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .expected (expected)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       locked;
    logic       pulse;
    logic [7:0] errc;
    logic [3:0] expv;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference state, advanced once per sampling edge.
  logic [3:0] m_cq, m_prev, m_exp;
  logic       m_mq, m_mqq, m_locked, m_pulse;
  logic [7:0] m_errc;
  int         m_state, m_idle, m_match;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_cq = '0; m_prev = '0; m_exp = '0; m_mq = 1'b0; m_mqq = 1'b0;
    m_locked = 1'b0; m_pulse = 1'b0; m_errc = '0;
    m_state = 0; m_idle = 0; m_match = 0;
  endtask

  task automatic apply(input logic [3:0] c, input logic m);
    logic up_ok, dn_ok, lg;
    count = c;
    mode  = m;
    up_ok = (m_cq == 4'(m_prev + 4'd1));
    dn_ok = (m_cq == 4'(m_prev - 4'd1));
    lg    = (m_mq == m_mqq) ? (m_mqq ? dn_ok : up_ok) : (up_ok || dn_ok);
    m_pulse = 1'b0;
    case (m_state)
      0: if (m_idle == 1) m_state = 1; else m_idle = 1;
      1: begin
        if (lg) begin
          m_match++;
          if (m_match == LOCK_N) begin m_state = 2; m_locked = 1'b1; end
        end else m_match = 0;
      end
      default: begin
        if (!lg) begin
          m_pulse = 1'b1;
          if (m_errc != 8'hFF) m_errc = m_errc + 8'd1;
          m_state = 1; m_match = 0; m_locked = 1'b0;
        end
      end
    endcase
    m_exp  = m_mq ? 4'(m_cq - 4'd1) : 4'(m_cq + 4'd1);
    m_prev = m_cq; m_cq = c; m_mqq = m_mq; m_mq = m;
    sb_q.push_back({m_locked, m_pulse, m_errc, m_exp});
  endtask

  task automatic step(input logic [3:0] c, input logic m);
    @(negedge clk);
    apply(c, m);
  endtask

  task automatic hand(input string name, input logic [31:0] act_sel, input logic [31:0] req);
    chk(name, act_sel, req);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one queued expectation per sampling edge once driving has begun.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        chk("locked",    32'(locked),    32'(mon_e.locked));
        chk("err_pulse", 32'(err_pulse), 32'(mon_e.pulse));
        chk("err_count", 32'(err_count), 32'(mon_e.errc));
        chk("expected",  32'(expected),  32'(mon_e.expv));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] c;
    model_reset();
    repeat (3) @(negedge clk);
    hand("reset_locked", 32'(locked), 0);
    hand("reset_err_count", 32'(err_count), 0);
    hand("reset_expected", 32'(expected), 0);
    rst = 1'b0;
    apply(4'h0, 1'b0);

    // Ideal up count: lock is declared on the edge sampling 5.
    for (int i = 1; i <= 4; i++) step(4'(i), 1'b0);
    settle();
    hand("lock_not_yet", 32'(locked), 0);
    step(4'h5, 1'b0);
    settle();
    hand("lock_after_n", 32'(locked), 1);
    hand("lock_expected", 32'(expected), 5);

    // Up through F->0 wrap, flip to down at 7 with one late up step to 8.
    for (int i = 6; i <= 23; i++) step(4'(i), 1'b0);
    step(4'h8, 1'b1);
    for (int i = 7; i >= -3; i--) step(4'(i), 1'b1);
    // Flip back to up with one late down step (D -> C), then up to 3.
    step(4'hC, 1'b0);
    for (int i = 13; i <= 19; i++) step(4'(i), 1'b0);
    settle();
    hand("wrap_flip_locked", 32'(locked), 1);
    hand("wrap_flip_errs", 32'(err_count), 0);

    // Skip 3 -> 5: error reported on the edge sampling 6.
    step(4'h5, 1'b0);
    step(4'h6, 1'b0);
    settle();
    hand("skip_pulse", 32'(err_pulse), 1);
    hand("skip_err_count", 32'(err_count), 1);
    hand("skip_unlocked", 32'(locked), 0);
    for (int i = 7; i <= 10; i++) step(4'(i), 1'b0);
    settle();
    hand("skip_relock", 32'(locked), 1);

    // Stall at A for two samples: one error, cumulative count now 2.
    step(4'hA, 1'b0);
    step(4'hB, 1'b0);
    settle();
    hand("stall_pulse", 32'(err_pulse), 1);
    hand("stall_err_count", 32'(err_count), 2);
    for (int i = 12; i <= 18; i++) step(4'(i), 1'b0);
    // Glitch 2 -> 9, then relock on 9..E.
    step(4'h9, 1'b0);
    for (int i = 10; i <= 14; i++) step(4'(i), 1'b0);
    settle();
    hand("glitch_err_count", 32'(err_count), 3);
    hand("glitch_relock", 32'(locked), 1);

    // Short async reset mid-TRACK clears everything without a clock edge.
    rst = 1'b1;
    model_reset();
    #1;
    hand("arst_locked", 32'(locked), 0);
    hand("arst_pulse", 32'(err_pulse), 0);
    hand("arst_err_count", 32'(err_count), 0);
    hand("arst_expected", 32'(expected), 0);
    rst = 1'b0;
    for (int i = 0; i <= 4; i++) step(4'(i), 1'b0);
    settle();
    hand("relock_not_yet", 32'(locked), 0);
    step(4'h5, 1'b0);
    settle();
    hand("relock_after_rst", 32'(locked), 1);

    // 300 stall errors, each followed by a relock: counter must stop at FF.
    c = 4'h5;
    for (int k = 0; k < 300; k++) begin
      step(c, 1'b0);
      for (int j = 1; j <= 4; j++) step(4'(c + 4'(j)), 1'b0);
      c = 4'(c + 4'd4);
    end
    step(c, 1'b0);
    step(4'(c + 4'd1), 1'b0);
    settle();
    hand("sat_err_count", 32'(err_count), 32'hFF);

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drain", 32'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
